conv_tile_scheduler: RTL and testbench

//  Sequencer for one Pix-wide convolution lane (kx*kx kernel loop, Pix MACs, row FIFO).

---
 rtl/conv_pkg.sv | 30 +++
 rtl/tile_counter.sv | 58 +++++
 rtl/conv_tile_scheduler.sv | 176 +++++++++++++++++
 tb/tb_conv_tile_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution tile scheduler.
// Holds the scheduler state encoding and the tile/index arithmetic used by both RTL files.
package conv_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD_W,
      S_FETCH,
      S_FIRE,
      S_COMPUTE,
      S_SETTLE,
      S_OUT,
      S_CLEAR,
      S_DONE
   } sched_state_t;

   // Index width that never collapses to zero bits for degenerate sizes.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int tiles_per_row(input int out_w, input int pix);
      return out_w / pix;
   endfunction

   function automatic int tiles_per_frame(input int out_w, input int out_h, input int pix);
      return tiles_per_row(out_w, pix) * out_h;
   endfunction

endpackage

// File: rtl/tile_counter.sv
// Raster tile position counter: x steps by PIX across a row, then y advances; 1-cycle update.
// No backpressure of its own; the scheduler decides when to clear or step.
module tile_counter
   import conv_pkg::*;
#(
   parameter int PIX   = 3,
   parameter int OUT_W = 12,
   parameter int OUT_H = 12,
   parameter int XW    = idx_w(OUT_W),
   parameter int YW    = idx_w(OUT_H)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          step,
   output logic [XW-1:0] tile_x,
   output logic [YW-1:0] tile_y,
   output logic          last_tile
);

   localparam logic [XW-1:0] X_LAST = XW'(OUT_W - PIX);
   localparam logic [YW-1:0] Y_LAST = YW'(OUT_H - 1);
   localparam logic [XW-1:0] X_STEP = XW'(PIX);

   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (clr) begin
         x_d = '0;
         y_d = '0;
      end else if (step) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
         end else begin
            x_d = x_q + X_STEP;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign tile_x    = x_q;
   assign tile_y    = y_q;
   assign last_tile = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/conv_tile_scheduler.sv
// Tile sequencer for one PIX-wide conv lane; per tile 4+KX*KX+SETTLE cycles with zero-wait handshakes.
// Holds row_req until row_valid and res_* until res_ready; abort overrides everything via CLEAR.
module conv_tile_scheduler
   import conv_pkg::*;
#(
   parameter int KX     = 3,
   parameter int PIX    = 3,
   parameter int RES    = 8,
   parameter int OUT_W  = 12,
   parameter int OUT_H  = 12,
   parameter int SETTLE = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         abort,
   output logic                         busy,
   output logic                         frame_done,
   output logic                         w_req,
   input  logic                         w_ack,
   output logic                         row_req,
   output logic [idx_w(OUT_H)-1:0]      row_y,
   output logic [idx_w(OUT_W)-1:0]      row_x,
   input  logic                         row_valid,
   output logic                         pixel_ready,
   output logic                         weight_ready,
   output logic                         mac_clear,
   input  logic                         kernel_done,
   input  logic [PIX*RES-1:0]           acc_in,
   output logic                         res_valid,
   input  logic                         res_ready,
   output logic [PIX*RES-1:0]           res_data,
   output logic [idx_w(OUT_H)-1:0]      res_y,
   output logic [idx_w(OUT_W)-1:0]      res_x
);

   localparam int XW = idx_w(OUT_W);
   localparam int YW = idx_w(OUT_H);
   localparam int SW = idx_w(SETTLE + 1);

   if ((OUT_W % PIX) != 0) begin : g_bad_width
      $error("conv_tile_scheduler: OUT_W must be a multiple of PIX");
   end

   sched_state_t        state_q, state_d;
   logic                aborting_q, aborting_d;
   logic                w_loaded_q, w_loaded_d;
   logic [SW-1:0]       settle_q, settle_d;
   logic [PIX*RES-1:0]  res_data_q, res_data_d;
   logic [XW-1:0]       res_x_q, res_x_d;
   logic [YW-1:0]       res_y_q, res_y_d;

   logic                cnt_clr, cnt_step, cnt_last;
   logic [XW-1:0]       cnt_x;
   logic [YW-1:0]       cnt_y;

   tile_counter #(
      .PIX   (PIX),
      .OUT_W (OUT_W),
      .OUT_H (OUT_H),
      .XW    (XW),
      .YW    (YW)
   ) u_tile_counter (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (cnt_clr),
      .step      (cnt_step),
      .tile_x    (cnt_x),
      .tile_y    (cnt_y),
      .last_tile (cnt_last)
   );

   always_comb begin
      state_d    = state_q;
      aborting_d = aborting_q;
      w_loaded_d = w_loaded_q;
      settle_d   = settle_q;
      res_data_d = res_data_q;
      res_x_d    = res_x_q;
      res_y_d    = res_y_q;
      cnt_clr    = 1'b0;
      cnt_step   = 1'b0;

      if (abort) begin
         state_d    = S_CLEAR;
         aborting_d = 1'b1;
         cnt_clr    = 1'b1;
      end else begin
         unique case (state_q)
            S_IDLE: if (start) begin
               state_d = S_LOAD_W;
               cnt_clr = 1'b1;
            end
            S_LOAD_W: if (w_ack) begin
               state_d    = S_FETCH;
               w_loaded_d = 1'b1;
            end
            S_FETCH: if (row_valid) state_d = S_FIRE;
            S_FIRE: state_d = S_COMPUTE;
            S_COMPUTE: if (kernel_done) begin
               if (SETTLE == 0) begin
                  state_d    = S_OUT;
                  res_data_d = acc_in;
                  res_x_d    = cnt_x;
                  res_y_d    = cnt_y;
               end else begin
                  state_d  = S_SETTLE;
                  settle_d = SW'(SETTLE - 1);
               end
            end
            // Accumulators are only final after the multiplier pipeline drains.
            S_SETTLE: if (settle_q == '0) begin
               state_d    = S_OUT;
               res_data_d = acc_in;
               res_x_d    = cnt_x;
               res_y_d    = cnt_y;
            end else begin
               settle_d = settle_q - SW'(1);
            end
            S_OUT: if (res_ready) state_d = S_CLEAR;
            S_CLEAR: begin
               if (aborting_q) begin
                  state_d    = S_IDLE;
                  aborting_d = 1'b0;
                  w_loaded_d = 1'b0;
                  cnt_clr    = 1'b1;
               end else if (cnt_last) begin
                  state_d    = S_DONE;
                  w_loaded_d = 1'b0;
                  cnt_clr    = 1'b1;
               end else begin
                  state_d  = S_FETCH;
                  cnt_step = 1'b1;
               end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         aborting_q <= 1'b0;
         w_loaded_q <= 1'b0;
         settle_q   <= '0;
         res_data_q <= '0;
         res_x_q    <= '0;
         res_y_q    <= '0;
      end else begin
         state_q    <= state_d;
         aborting_q <= aborting_d;
         w_loaded_q <= w_loaded_d;
         settle_q   <= settle_d;
         res_data_q <= res_data_d;
         res_x_q    <= res_x_d;
         res_y_q    <= res_y_d;
      end
   end

   assign busy         = (state_q != S_IDLE);
   assign frame_done   = (state_q == S_DONE);
   assign w_req        = (state_q == S_LOAD_W);
   assign row_req      = (state_q == S_FETCH);
   assign pixel_ready  = (state_q == S_FIRE);
   assign mac_clear    = (state_q == S_CLEAR);
   assign res_valid    = (state_q == S_OUT);
   assign weight_ready = w_loaded_q;
   assign row_x        = cnt_x;
   assign row_y        = cnt_y;
   assign res_data     = res_data_q;
   assign res_x        = res_x_q;
   assign res_y        = res_y_q;

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Directed frame sequence with randomized handshake delays and accumulator values;
// expected tile order, coordinates and timing come from plain tile arithmetic.
module tb_conv_tile_scheduler;
   import conv_pkg::*;

   localparam int KX = 3, PIX = 3, RES = 8, OUT_W = 6, OUT_H = 2, SETTLE = 1;
   localparam int DW = PIX * RES;
   localparam int TPR = OUT_W / PIX;
   localparam int NT = TPR * OUT_H;
   localparam int TILE_LAT = 1 + 1 + KX * KX + SETTLE + 1 + 1;

   logic clk, rst_n, start, abort, w_ack, row_valid, kernel_done, res_ready;
   logic busy, frame_done, w_req, row_req, pixel_ready, weight_ready, mac_clear, res_valid;
   logic [idx_w(OUT_H)-1:0] row_y, res_y;
   logic [idx_w(OUT_W)-1:0] row_x, res_x;
   logic [DW-1:0] acc_in, res_data;

   int ntests = 0, nfail = 0, cyc = 0, last_fire = 0, clears = 0;

   conv_tile_scheduler #(
      .KX(KX), .PIX(PIX), .RES(RES), .OUT_W(OUT_W), .OUT_H(OUT_H), .SETTLE(SETTLE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy),
      .frame_done(frame_done), .w_req(w_req), .w_ack(w_ack), .row_req(row_req),
      .row_y(row_y), .row_x(row_x), .row_valid(row_valid), .pixel_ready(pixel_ready),
      .weight_ready(weight_ready), .mac_clear(mac_clear), .kernel_done(kernel_done),
      .acc_in(acc_in), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_y(res_y), .res_x(res_x)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout tests=%0d", ntests);
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One tile from FETCH to the cycle after CLEAR; optional abort or reset injection.
   task automatic run_tile(input int t, input int row_dly, input int rdy_dly, input logic [DW-1:0] acc,
                           input bit per, input bit ab, input bit rs, input bit kd_early);
      int ey, ex, fire_cyc;
      ey = t / TPR;
      ex = (t % TPR) * PIX;
      chk("fetch_row_req", row_req, 1);
      chk("fetch_row_y", row_y, ey);
      chk("fetch_row_x", row_x, ex);
      chk("fetch_wready", weight_ready, 1);
      kernel_done = kd_early;
      for (int i = 0; i < row_dly; i++) begin
         tick;
         chk("wait_row_req", row_req, 1);
         chk("wait_row_y", row_y, ey);
         chk("wait_row_x", row_x, ex);
         chk("wait_no_pix", pixel_ready, 0);
      end
      row_valid = 1'b1;
      tick;
      row_valid = 1'b0;
      chk("fire_pix", pixel_ready, 1);
      chk("fire_row_req", row_req, 0);
      fire_cyc = cyc;
      if (per) chk("tile_period", fire_cyc - last_fire, TILE_LAT);
      last_fire = fire_cyc;
      acc_in = ~acc;
      tick;
      kernel_done = 1'b0;
      start = 1'b1;
      chk("pix_single", pixel_ready, 0);
      chk("compute_busy", busy, 1);
      for (int k = 1; k < KX * KX; k++) begin
         tick;
         start = 1'b0;
         chk("compute_no_res", res_valid, 0);
      end
      start = 1'b0;
      kernel_done = 1'b1;
      acc_in = acc;
      abort = ab;
      tick;
      kernel_done = 1'b0;
      abort = 1'b0;
      if (ab) begin
         chk("abort_clear", mac_clear, 1);
         chk("abort_no_res", res_valid, 0);
         chk("abort_busy1", busy, 1);
         tick;
         chk("abort_idle", busy, 0);
         chk("abort_clear_once", mac_clear, 0);
         chk("abort_row_x0", row_x, 0);
         chk("abort_row_y0", row_y, 0);
         for (int i = 0; i < 3; i++) begin
            tick;
            chk("abort_quiet_res", res_valid, 0);
            chk("abort_quiet_done", frame_done, 0);
         end
         return;
      end
      for (int i = 0; i < SETTLE; i++) begin
         chk("settle_no_res", res_valid, 0);
         tick;
      end
      chk("out_valid", res_valid, 1);
      chk("out_latency", cyc - fire_cyc, 1 + KX * KX + SETTLE);
      chk("out_data", res_data, acc);
      chk("out_y", res_y, ey);
      chk("out_x", res_x, ex);
      acc_in = DW'($urandom);
      if (rs) begin
         rst_n = 1'b0;
         #1;
         chk("rst_busy", busy, 0);
         chk("rst_res_valid", res_valid, 0);
         chk("rst_res_data", res_data, 0);
         chk("rst_res_x", res_x, 0);
         chk("rst_wready", weight_ready, 0);
         chk("rst_mac_clear", mac_clear, 0);
         chk("rst_row_x", row_x, 0);
         tick;
         tick;
         rst_n = 1'b1;
         return;
      end
      for (int i = 0; i < rdy_dly; i++) begin
         tick;
         chk("hold_valid", res_valid, 1);
         chk("hold_data", res_data, acc);
         chk("hold_y", res_y, ey);
         chk("hold_x", res_x, ex);
         chk("hold_no_fetch", row_req, 0);
         chk("hold_no_clear", mac_clear, 0);
      end
      res_ready = 1'b1;
      tick;
      res_ready = 1'b0;
      chk("clear_pulse", mac_clear, 1);
      chk("clear_no_res", res_valid, 0);
      if (mac_clear) clears++;
      tick;
   endtask

   task automatic run_frame(input int wdly, input bit rnd, input int ab_tile, input int rs_tile);
      int rd, yd, prev_rdy;
      logic [DW-1:0] acc;
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_w_req", w_req, 1);
      for (int i = 0; i < wdly; i++) begin
         tick;
         chk("wait_w_req", w_req, 1);
         chk("wait_no_fetch", row_req, 0);
      end
      w_ack = 1'b1;
      tick;
      w_ack = 1'b0;
      chk("loaded_w_req", w_req, 0);
      chk("loaded_wready", weight_ready, 1);
      clears = 0;
      prev_rdy = 1;
      for (int t = 0; t < NT; t++) begin
         rd = rnd ? int'($urandom_range(0, 3)) : 0;
         yd = rnd ? int'($urandom_range(0, 3)) : 0;
         if (rnd && t == 1) rd = 7;
         if (rnd && t == 2) yd = 5;
         acc = rnd ? DW'($urandom) : DW'(24'h030201);
         run_tile(t, rd, yd, acc, (t > 0) && (prev_rdy == 0) && (rd == 0),
                  t == ab_tile, t == rs_tile, rnd && t == 0);
         if (t == ab_tile || t == rs_tile) return;
         prev_rdy = yd;
      end
      chk("frame_done", frame_done, 1);
      chk("done_busy", busy, 1);
      chk("clears_per_frame", clears, NT);
      tick;
      chk("done_pulse", frame_done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_wready", weight_ready, 0);
      tick;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; w_ack = 1'b0; row_valid = 1'b0;
      kernel_done = 1'b0; res_ready = 1'b0; acc_in = '0;
      #2;
      chk("reset_busy", busy, 0);
      chk("reset_res_valid", res_valid, 0);
      chk("reset_res_data", res_data, 0);
      chk("reset_row_y", row_y, 0);
      chk("reset_w_req", w_req, 0);
      tick;
      tick;
      rst_n = 1'b1;
      tick;
      chk("idle_no_req", w_req, 0);

      run_frame(0, 1'b0, -1, -1);
      run_frame(2, 1'b1, -1, -1);
      run_frame(1, 1'b0, 2, -1);
      run_frame(0, 1'b0, -1, 1);
      run_frame(int'($urandom_range(0, 3)), 1'b1, -1, -1);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
